dat_xfer_ctrl: RTL and testbench

DAT_XFER_CTRL -- requirements
Module: dat_xfer_ctrl

---
 rtl/sdio_dat_pkg.sv | 50 +++++
 rtl/dat_xfer_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_dat_xfer_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdio_dat_pkg.sv
// Shared definitions for the SD data-line transfer controller.
// Contents: controller state encoding, data-lane phase codes, status token patterns,
// receive start-bit timeout, maximum block length and the CRC16 field length.
package sdio_dat_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StTxPre,
      StTxStart,
      StTxData,
      StTxCrc,
      StTxEnd,
      StRxWait,
      StRxData,
      StRxCrc,
      StRxEnd,
      StRxStat,
      StDone
   } xfer_state_e;

   // Lane phase codes
   localparam logic [1:0] PhDrive0 = 2'b00;
   localparam logic [1:0] PhDrive1 = 2'b01;
   localparam logic [1:0] PhData   = 2'b10;
   localparam logic [1:0] PhCrc    = 2'b11;

   // Status tokens, MSB goes out first
   localparam logic [4:0] TokenOk  = 5'b00101;
   localparam logic [4:0] TokenBad = 5'b01011;
   localparam int unsigned TokenLen = 5;

   localparam int unsigned TimeoutClks = 1024;
   localparam int unsigned MaxBlkLen   = 512;
   localparam int unsigned CrcClks     = 16;

   // Index of the final byte of a block; a length field of 0 means MaxBlkLen bytes.
   function automatic logic [9:0] last_byte_idx(input logic [9:0] blk_len);
      logic [9:0] n;
      n = (blk_len == 10'd0) ? 10'(MaxBlkLen) : blk_len;
      return n - 10'd1;
   endfunction

   // Token bit for position idx (0 = first bit on the wire).
   function automatic logic token_bit(input logic fail, input logic [2:0] idx);
      logic [4:0] tok;
      tok = fail ? TokenBad : TokenOk;
      return tok[3'd4 - idx];
   endfunction

endpackage

// File: rtl/dat_xfer_ctrl.sv
// SD data-line block transfer controller.
// Sequences one block per start request, card-to-host (start_tx) or host-to-card (start_rx),
// and drives the external data lane and CRC16 through phase/select controls.
// Ports:
//   clk, rst                : clock, synchronous active-low reset
//   start_tx, start_rx      : one-cycle block requests (tx wins if both)
//   blk_len                 : block length in bytes, 0 = 512, sampled on start
//   tx_byte, tx_vld, tx_rd  : byte source, consumed when tx_rd=1
//   rx_byte, rx_vld         : received byte, valid for one cycle
//   dat_phase, xmit_data,
//   data_sel, oe, crc_rst,
//   crc_check_en            : lane controls
//   rcv_data, crc_error     : lane sampled data (bit0 used) and CRC mismatch flag
//   busy, done, crc_fail,
//   underrun, timeout       : status; done is a one-cycle pulse
module dat_xfer_ctrl
   import sdio_dat_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start_tx,
   input  logic       start_rx,
   input  logic [9:0] blk_len,
   input  logic [7:0] tx_byte,
   input  logic       tx_vld,
   output logic       tx_rd,
   output logic [7:0] rx_byte,
   output logic       rx_vld,
   output logic [1:0] dat_phase,
   output logic [1:0] xmit_data,
   output logic       data_sel,
   output logic       oe,
   output logic       crc_rst,
   output logic       crc_check_en,
   input  logic [1:0] rcv_data,
   input  logic       crc_error,
   output logic       busy,
   output logic       done,
   output logic       crc_fail,
   output logic       underrun,
   output logic       timeout
);

   xfer_state_e state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [9:0]  byte_cnt_q, byte_cnt_d;
   logic [9:0]  last_byte_q, last_byte_d;
   // Shared cycle counter for the start-bit wait, CRC field and status token
   logic [9:0]  seq_cnt_q, seq_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic        rx_vld_q, rx_vld_d;
   logic        crc_fail_q, crc_fail_d;
   logic        underrun_q, underrun_d;
   logic        timeout_q, timeout_d;

   logic        last_bit;
   logic        last_byte;
   logic        unused_rcv;

   // Only the one-clock-delayed lane sample is used
   assign unused_rcv = rcv_data[1];

   assign last_bit  = (bit_cnt_q == 3'd7);
   assign last_byte = (byte_cnt_q == last_byte_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         bit_cnt_q   <= 3'd0;
         byte_cnt_q  <= 10'd0;
         last_byte_q <= 10'd0;
         seq_cnt_q   <= 10'd0;
         shift_q     <= 8'd0;
         rx_byte_q   <= 8'd0;
         rx_vld_q    <= 1'b0;
         crc_fail_q  <= 1'b0;
         underrun_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         last_byte_q <= last_byte_d;
         seq_cnt_q   <= seq_cnt_d;
         shift_q     <= shift_d;
         rx_byte_q   <= rx_byte_d;
         rx_vld_q    <= rx_vld_d;
         crc_fail_q  <= crc_fail_d;
         underrun_q  <= underrun_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      last_byte_d  = last_byte_q;
      seq_cnt_d    = seq_cnt_q;
      shift_d      = shift_q;
      rx_byte_d    = rx_byte_q;
      rx_vld_d     = 1'b0;
      crc_fail_d   = crc_fail_q;
      underrun_d   = underrun_q;
      timeout_d    = timeout_q;

      dat_phase    = PhDrive1;
      xmit_data    = 2'b11;
      data_sel     = 1'b0;
      oe           = 1'b0;
      crc_rst      = 1'b0;
      crc_check_en = 1'b0;
      tx_rd        = 1'b0;

      unique case (state_q)
         StIdle: begin
            crc_rst = 1'b1;
            if (start_tx || start_rx) begin
               last_byte_d = last_byte_idx(blk_len);
               bit_cnt_d   = 3'd0;
               byte_cnt_d  = 10'd0;
               seq_cnt_d   = 10'd0;
               crc_fail_d  = 1'b0;
               underrun_d  = 1'b0;
               timeout_d   = 1'b0;
               state_d     = start_tx ? StTxPre : StRxWait;
            end
         end

         StTxPre: begin
            oe        = 1'b1;
            dat_phase = PhDrive1;
            state_d   = StTxStart;
         end

         StTxStart: begin
            oe        = 1'b1;
            dat_phase = PhDrive0;
            tx_rd     = 1'b1;
            shift_d   = tx_vld ? tx_byte : 8'hFF;
            if (!tx_vld) underrun_d = 1'b1;
            state_d   = StTxData;
         end

         StTxData: begin
            oe        = 1'b1;
            dat_phase = PhData;
            // Pair k = bit_cnt[2:1]; data_sel picks the upper bit first
            case (bit_cnt_q[2:1])
               2'd0:    xmit_data = shift_q[7:6];
               2'd1:    xmit_data = shift_q[5:4];
               2'd2:    xmit_data = shift_q[3:2];
               default: xmit_data = shift_q[1:0];
            endcase
            data_sel  = bit_cnt_q[0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
               if (last_byte) begin
                  seq_cnt_d = 10'd0;
                  state_d   = StTxCrc;
               end else begin
                  tx_rd      = 1'b1;
                  shift_d    = tx_vld ? tx_byte : 8'hFF;
                  if (!tx_vld) underrun_d = 1'b1;
                  byte_cnt_d = byte_cnt_q + 10'd1;
               end
            end
         end

         StTxCrc: begin
            oe        = 1'b1;
            dat_phase = PhCrc;
            seq_cnt_d = seq_cnt_q + 10'd1;
            if (seq_cnt_q == 10'(CrcClks - 1)) state_d = StTxEnd;
         end

         StTxEnd: begin
            oe        = 1'b1;
            dat_phase = PhDrive1;
            state_d   = StDone;
         end

         StRxWait: begin
            crc_check_en = 1'b1;
            if (!rcv_data[0]) begin
               bit_cnt_d  = 3'd0;
               byte_cnt_d = 10'd0;
               state_d    = StRxData;
            end else if (seq_cnt_q == 10'(TimeoutClks - 1)) begin
               timeout_d = 1'b1;
               state_d   = StDone;
            end else begin
               seq_cnt_d = seq_cnt_q + 10'd1;
            end
         end

         StRxData: begin
            crc_check_en = 1'b1;
            dat_phase    = PhData;
            shift_d      = {shift_q[6:0], rcv_data[0]};
            bit_cnt_d    = bit_cnt_q + 3'd1;
            if (last_bit) begin
               rx_vld_d  = 1'b1;
               rx_byte_d = {shift_q[6:0], rcv_data[0]};
               if (last_byte) begin
                  seq_cnt_d = 10'd0;
                  state_d   = StRxCrc;
               end else begin
                  byte_cnt_d = byte_cnt_q + 10'd1;
               end
            end
         end

         StRxCrc: begin
            crc_check_en = 1'b1;
            dat_phase    = PhCrc;
            if (crc_error) crc_fail_d = 1'b1;
            seq_cnt_d    = seq_cnt_q + 10'd1;
            if (seq_cnt_q == 10'(CrcClks - 1)) state_d = StRxEnd;
         end

         StRxEnd: begin
            crc_check_en = 1'b1;
            if (!rcv_data[0]) crc_fail_d = 1'b1;
            seq_cnt_d    = 10'd0;
            state_d      = StRxStat;
         end

         StRxStat: begin
            oe        = 1'b1;
            dat_phase = token_bit(crc_fail_q, seq_cnt_q[2:0]) ? PhDrive1 : PhDrive0;
            seq_cnt_d = seq_cnt_q + 10'd1;
            if (seq_cnt_q == 10'(TokenLen - 1)) state_d = StDone;
         end

         StDone: begin
            crc_rst = 1'b1;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   assign rx_byte  = rx_byte_q;
   assign rx_vld   = rx_vld_q;
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign crc_fail = crc_fail_q;
   assign underrun = underrun_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_dat_xfer_ctrl.sv
// Self-checking bench for dat_xfer_ctrl: directed and randomized block transfers
// compared against a cycle-count/bitstream model of the block protocol.
module tb_dat_xfer_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_tx = 1'b0;
   logic       start_rx = 1'b0;
   logic [9:0] blk_len = 10'd1;
   logic [7:0] tx_byte = 8'd0;
   logic       tx_vld = 1'b0;
   logic       tx_rd;
   logic [7:0] rx_byte;
   logic       rx_vld;
   logic [1:0] dat_phase;
   logic [1:0] xmit_data;
   logic       data_sel;
   logic       oe;
   logic       crc_rst;
   logic       crc_check_en;
   logic [1:0] rcv_data = 2'b11;
   logic       crc_error = 1'b0;
   logic       busy;
   logic       done;
   logic       crc_fail;
   logic       underrun;
   logic       timeout;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [7:0] tx_src_q[$];
   bit         tx_vld_q[$];
   logic [7:0] rx_src_q[$];

   always #5 clk = ~clk;

   dat_xfer_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start_tx     (start_tx),
      .start_rx     (start_rx),
      .blk_len      (blk_len),
      .tx_byte      (tx_byte),
      .tx_vld       (tx_vld),
      .tx_rd        (tx_rd),
      .rx_byte      (rx_byte),
      .rx_vld       (rx_vld),
      .dat_phase    (dat_phase),
      .xmit_data    (xmit_data),
      .data_sel     (data_sel),
      .oe           (oe),
      .crc_rst      (crc_rst),
      .crc_check_en (crc_check_en),
      .rcv_data     (rcv_data),
      .crc_error    (crc_error),
      .busy         (busy),
      .done         (done),
      .crc_fail     (crc_fail),
      .underrun     (underrun),
      .timeout      (timeout)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic prep_tx(input int unsigned n, input int unsigned miss_pct);
      tx_src_q.delete();
      tx_vld_q.delete();
      for (int i = 0; i < n; i++) begin
         tx_src_q.push_back(8'($urandom));
         tx_vld_q.push_back($urandom_range(0, 99) >= miss_pct);
      end
   endtask

   task automatic prep_rx(input int unsigned n);
      rx_src_q.delete();
      for (int i = 0; i < n; i++) rx_src_q.push_back(8'($urandom));
   endtask

   // Transmit one block; called at a negedge with the DUT idle.
   task automatic run_tx(input logic [9:0] len_field, input bit poke);
      int unsigned n, end_c, n_rd;
      bit          bits[$];
      bit          exp_ur, exp_rd;
      logic [1:0]  ph;
      logic [7:0]  b, e;
      n      = (len_field == 10'd0) ? 512 : int'(len_field);
      end_c  = 8 * n + 20;
      n_rd   = 0;
      exp_ur = 1'b0;
      foreach (tx_vld_q[i]) if (!tx_vld_q[i]) exp_ur = 1'b1;
      start_tx = 1'b1;
      start_rx = poke;
      blk_len  = len_field;
      for (int c = 1; c <= int'(end_c); c++) begin
         @(negedge clk);
         start_tx = 1'b0;
         start_rx = poke ? 1'($urandom) : 1'b0;
         if (c == int'(end_c)) begin
            check_eq("tx_done", done, 1);
            check_eq("tx_done_oe", oe, 0);
            check_eq("tx_done_crc_rst", crc_rst, 1);
            check_eq("tx_underrun", underrun, exp_ur);
            break;
         end
         if (c == 1 || c == int'(end_c) - 1) ph = 2'b01;
         else if (c == 2)                     ph = 2'b00;
         else if (c <= int'(8 * n) + 2)       ph = 2'b10;
         else                                 ph = 2'b11;
         exp_rd = (c == 2) || (c >= 10 && c + 6 <= int'(8 * n) && (c - 2) % 8 == 0);
         check_eq("tx_phase", dat_phase, ph);
         check_eq("tx_oe", oe, 1);
         check_eq("tx_crc_rst", crc_rst, 0);
         check_eq("tx_busy", busy, 1);
         check_eq("tx_done_early", done, 0);
         check_eq("tx_rd", tx_rd, exp_rd);
         if (ph == 2'b10) begin
            bits.push_back(data_sel ? xmit_data[0] : xmit_data[1]);
            check_eq("tx_sel", data_sel, (c - 3) % 2);
         end else begin
            check_eq("tx_lane_idle", xmit_data, 2'b11);
         end
         if (tx_rd) begin
            if (n_rd < n) begin
               tx_vld  = tx_vld_q[n_rd];
               tx_byte = tx_src_q[n_rd];
            end
            n_rd++;
         end else begin
            tx_vld  = 1'($urandom);
            tx_byte = 8'($urandom);
         end
      end
      start_rx = 1'b0;
      check_eq("tx_reads", n_rd, n);
      check_eq("tx_bit_count", bits.size(), 8 * n);
      if (bits.size() == 8 * n) begin
         for (int i = 0; i < int'(n); i++) begin
            b = 8'd0;
            for (int j = 0; j < 8; j++) b = {b[6:0], bits[8 * i + j]};
            e = tx_vld_q[i] ? tx_src_q[i] : 8'hFF;
            check_eq("tx_byte", b, e);
         end
      end
      @(negedge clk);
      check_eq("tx_after_busy", busy, 0);
      check_eq("tx_after_done", done, 0);
      check_eq("tx_underrun_sticky", underrun, exp_ur);
   endtask

   // Receive one block: w idle-high clocks, start bit, data, CRC field, end bit.
   task automatic run_rx(input logic [9:0] len_field, input int unsigned w, input bit crc_err,
                         input bit end_bit, input bit noise);
      int unsigned n, ci;
      int          d0, c0, e, t0, done_c;
      bit          fail, bitv;
      logic [4:0]  tokv;
      logic [7:0]  sb;
      logic [7:0]  got[$];
      n      = (len_field == 10'd0) ? 512 : int'(len_field);
      d0     = int'(w) + 2;
      c0     = d0 + int'(8 * n);
      e      = c0 + 16;
      t0     = e + 1;
      done_c = t0 + 5;
      fail   = crc_err || !end_bit;
      tokv   = fail ? 5'b01011 : 5'b00101;
      ci     = $urandom_range(0, 15);
      start_rx = 1'b1;
      start_tx = 1'b0;
      blk_len  = len_field;
      rcv_data = 2'b11;
      for (int c = 1; c <= done_c; c++) begin
         @(negedge clk);
         start_rx = 1'b0;
         start_tx = noise ? 1'($urandom) : 1'b0;
         if (rx_vld) got.push_back(rx_byte);
         if (c == done_c) begin
            check_eq("rx_done", done, 1);
            check_eq("rx_crc_fail", crc_fail, fail);
            check_eq("rx_timeout", timeout, 0);
            check_eq("rx_done_oe", oe, 0);
            check_eq("rx_done_crc_rst", crc_rst, 1);
            break;
         end
         check_eq("rx_busy", busy, 1);
         check_eq("rx_done_early", done, 0);
         check_eq("rx_crc_rst", crc_rst, 0);
         if (c <= e) begin
            check_eq("rx_oe", oe, 0);
            check_eq("rx_crc_chk", crc_check_en, 1);
            if (c >= d0 && c < c0) check_eq("rx_phase_data", dat_phase, 2'b10);
            if (c >= c0 && c < e)  check_eq("rx_phase_crc", dat_phase, 2'b11);
         end else begin
            check_eq("rx_tok_oe", oe, 1);
            check_eq("rx_tok_crc_chk", crc_check_en, 0);
            check_eq("rx_token", dat_phase, {1'b0, tokv[4 - (c - t0)]});
         end
         if (c <= int'(w))  bitv = 1'b1;
         else if (c == int'(w) + 1) bitv = 1'b0;
         else if (c < c0) begin
            sb   = rx_src_q[(c - d0) / 8];
            bitv = sb[7 - (c - d0) % 8];
         end else if (c < e) bitv = 1'($urandom);
         else if (c == e)    bitv = end_bit;
         else                bitv = 1'b1;
         rcv_data = {1'($urandom), bitv};
         if (c >= c0 && c < e) crc_error = crc_err && (c == c0 + int'(ci));
         else if (c < c0)      crc_error = noise ? 1'($urandom) : 1'b0;
         else                  crc_error = 1'b0;
      end
      start_tx  = 1'b0;
      crc_error = 1'b0;
      rcv_data  = 2'b11;
      check_eq("rx_byte_count", got.size(), n);
      if (got.size() == n) begin
         foreach (got[i]) check_eq("rx_byte", got[i], rx_src_q[i]);
      end
      @(negedge clk);
      check_eq("rx_after_busy", busy, 0);
      check_eq("rx_crc_fail_sticky", crc_fail, fail);
   endtask

   task automatic run_timeout();
      int unsigned n_vld;
      n_vld    = 0;
      start_rx = 1'b1;
      rcv_data = 2'b11;
      for (int c = 1; c <= 1025; c++) begin
         @(negedge clk);
         start_rx = 1'b0;
         if (rx_vld) n_vld++;
         if (c == 1025) begin
            check_eq("to_done", done, 1);
            check_eq("to_timeout", timeout, 1);
            check_eq("to_crc_fail", crc_fail, 0);
            break;
         end
         check_eq("to_done_early", done, 0);
         if (c % 256 == 0 || c == 1024) begin
            check_eq("to_oe", oe, 0);
            check_eq("to_crc_chk", crc_check_en, 1);
            check_eq("to_busy", busy, 1);
         end
      end
      check_eq("to_no_bytes", n_vld, 0);
      @(negedge clk);
      check_eq("to_after_busy", busy, 0);
      check_eq("to_after_done", done, 0);
   endtask

   task automatic run_reset_mid_tx();
      int unsigned n_rd, n_done;
      prep_tx(3, 0);
      tx_vld_q[0] = 1'b0;
      n_rd     = 0;
      start_tx = 1'b1;
      blk_len  = 10'd3;
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         start_tx = 1'b0;
         if (tx_rd) begin
            tx_vld  = tx_vld_q[n_rd % 3];
            tx_byte = tx_src_q[n_rd % 3];
            n_rd++;
         end
      end
      check_eq("rst_pre_phase", dat_phase, 2'b10);
      check_eq("rst_pre_underrun", underrun, 1);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_oe", oe, 0);
      check_eq("rst_crc_rst", crc_rst, 1);
      check_eq("rst_done", done, 0);
      check_eq("rst_phase", dat_phase, 2'b01);
      check_eq("rst_xmit", xmit_data, 2'b11);
      check_eq("rst_sel", data_sel, 0);
      check_eq("rst_tx_rd", tx_rd, 0);
      check_eq("rst_rx_vld", rx_vld, 0);
      check_eq("rst_rx_byte", rx_byte, 0);
      check_eq("rst_underrun", underrun, 0);
      check_eq("rst_crc_fail", crc_fail, 0);
      rst    = 1'b1;
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check_eq("rst_no_done", n_done, 0);
      check_eq("rst_stays_idle", busy, 0);
   endtask

   initial begin
      logic [9:0] len;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_phase", dat_phase, 2'b01);
      check_eq("reset_oe", oe, 0);
      check_eq("reset_crc_rst", crc_rst, 1);
      check_eq("reset_crc_chk", crc_check_en, 0);
      check_eq("reset_xmit", xmit_data, 2'b11);
      check_eq("reset_sel", data_sel, 0);
      check_eq("reset_tx_rd", tx_rd, 0);
      check_eq("reset_rx_vld", rx_vld, 0);
      check_eq("reset_rx_byte", rx_byte, 0);
      check_eq("reset_flags", {busy, done, crc_fail, underrun, timeout}, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single byte 0xA5, start_rx also asserted to exercise tx priority
      tx_src_q = '{8'hA5};
      tx_vld_q = '{1'b1};
      run_tx(10'd1, 1'b1);

      // Second byte unavailable: goes out as 0xFF with underrun
      tx_src_q = '{8'h5A, 8'h3C};
      tx_vld_q = '{1'b1, 1'b0};
      run_tx(10'd2, 1'b0);

      rx_src_q = '{8'h3C};
      run_rx(10'd1, 3, 1'b0, 1'b1, 1'b0);
      rx_src_q = '{8'h3C};
      run_rx(10'd1, 5, 1'b1, 1'b1, 1'b0);
      prep_rx(2);
      run_rx(10'd2, 0, 1'b0, 1'b0, 1'b1);

      run_timeout();
      // Start bit on the last clock before the timeout would fire
      prep_rx(1);
      run_rx(10'd1, 1023, 1'b0, 1'b1, 1'b0);

      // Length field 0 means 512 bytes
      prep_tx(512, 2);
      run_tx(10'd0, 1'b1);
      prep_rx(512);
      run_rx(10'd0, 7, 1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 10; i++) begin
         len = 10'($urandom_range(1, 6));
         if ($urandom_range(0, 1) == 0) begin
            prep_tx(int'(len), 20);
            run_tx(len, 1'($urandom));
         end else begin
            prep_rx(int'(len));
            run_rx(len, $urandom_range(0, 30), 1'($urandom), ($urandom_range(0, 3) != 0),
                   1'($urandom));
         end
      end

      run_reset_mid_tx();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
